// File: rtl/modulo_360_pkg.sv
// ---------------------------------------------------------------------------
// modulo_360_pkg
// Shared constants and helper functions for the modulo-360 phase reducer.
//
// Contents:
//   MOD_VAL / MOD_HI / MOD_LO_BITS : 360 = 45 * 2^3 decomposition
//   RES_2P6 / RES_2P12             : 2^6 mod 45 and 2^12 mod 45
//   IN_W_DEF / OUT_W_DEF           : default port widths of modulo_360
//   LATENCY                        : clocks from in to modulo
//   pow2_mod45()                   : 2^k mod 45, used to weight the quotient bits
//   sel45()                        : final compare-select of the fold sum to 0..44
//
// Build option: MODULO_360_PIPE_EN adds one pipeline stage (LATENCY = 2).
// ---------------------------------------------------------------------------
package modulo_360_pkg;

    localparam int IN_W_DEF    = 16;
    localparam int OUT_W_DEF   = 9;

    localparam int MOD_VAL     = 360;
    localparam int MOD_HI      = 45;
    localparam int MOD_LO_BITS = 3;

    // Quotient width, residue width and width of the folded sum (0..120).
    localparam int Q_W         = IN_W_DEF - MOD_LO_BITS;
    localparam int R45_W       = 6;
    localparam int FOLD_W      = 7;

    localparam logic [5:0] RES_2P6  = 6'd19;
    localparam logic [5:0] RES_2P12 = 6'd1;

`ifdef MODULO_360_PIPE_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

    // Elaboration-time residue of 2^k modulo 45.
    function automatic logic [5:0] pow2_mod45(input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) begin
            r = r * 2;
            if (r >= MOD_HI) begin
                r = r - MOD_HI;
            end
        end
        return r[5:0];
    endfunction

    // The folded sum never exceeds 120, so subtracting 90 or 45 is enough.
    function automatic logic [R45_W-1:0] sel45(input logic [FOLD_W-1:0] s);
        logic [FOLD_W-1:0] d;
        if (s >= 7'd90) begin
            d = s - 7'd90;
        end else if (s >= 7'd45) begin
            d = s - 7'd45;
        end else begin
            d = s;
        end
        return d[R45_W-1:0];
    endfunction

endpackage

// File: rtl/mod45_fold.sv
// ---------------------------------------------------------------------------
// mod45_fold
// Combinational reducer: 13-bit quotient -> residue mod 45 (0..44).
//
// Ports:
//   q        in   13  value to reduce
//   fold_sum out   7  folded sum congruent to q mod 45, range 0..120
//   r45      out   6  q mod 45, range 0..44
//
// Each set bit of q contributes 2^k mod 45. Those residues add up to at
// most 226; folding the 2^6 weight of that sum once more brings it to at
// most 120, which sel45() finishes with a compare-select against 45/90.
// ---------------------------------------------------------------------------
module mod45_fold
    import modulo_360_pkg::*;
(
    input  logic [Q_W-1:0]    q,
    output logic [FOLD_W-1:0] fold_sum,
    output logic [R45_W-1:0]  r45
);

    logic [7:0] term [Q_W];
    logic [7:0] bit_sum;

    genvar gi;
    generate
        for (gi = 0; gi < Q_W; gi++) begin : g_term
            localparam logic [5:0] RES = pow2_mod45(gi);
            assign term[gi] = q[gi] ? {2'b00, RES} : 8'd0;
        end
    endgenerate

    always_comb begin
        bit_sum = 8'd0;
        for (int i = 0; i < Q_W; i++) begin
            bit_sum = bit_sum + term[i];
        end
    end

    // bits [7:6] of bit_sum weigh 64 = 19 (mod 45)
    assign fold_sum = {1'b0, bit_sum[5:0]} + 7'(bit_sum[7:6]) * 7'(RES_2P6);
    assign r45      = sel45(fold_sum);

endmodule

// File: rtl/modulo_360.sv
// ---------------------------------------------------------------------------
// modulo_360
// Registered modulo-360 reducer for the NCO phase path.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   in      in   IN_W   unsigned value, sampled every edge
//   modulo  out  OUT_W  in mod 360, registered, always 0..359
//
// 360 = 45 * 8: the low three bits pass straight through and the upper
// 13 bits are reduced mod 45, giving modulo = r45 * 8 + in[2:0].
//
// Build option MODULO_360_PIPE_EN: registers the fold sum before the final
// compare-select, latency 2 instead of 1. Results are identical.
// ---------------------------------------------------------------------------
module modulo_360
    import modulo_360_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] modulo
);

    logic [MOD_LO_BITS-1:0] r8;
    logic [Q_W-1:0]         q;
    logic [OUT_W-1:0]       modulo_reg;
    logic [OUT_W-1:0]       modulo_next;

    assign r8 = in[MOD_LO_BITS-1:0];
    assign q  = in[IN_W-1:MOD_LO_BITS];

`ifdef MODULO_360_PIPE_EN
    logic [FOLD_W-1:0]      fold_sum;
    logic [R45_W-1:0]       unused_r45;
    logic [FOLD_W-1:0]      sum_reg;
    logic [MOD_LO_BITS-1:0] r8_reg;

    mod45_fold u_fold (
        .q        (q),
        .fold_sum (fold_sum),
        .r45      (unused_r45)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
            r8_reg  <= '0;
        end else begin
            sum_reg <= fold_sum;
            r8_reg  <= r8;
        end
    end

    assign modulo_next = OUT_W'({sel45(sum_reg), r8_reg});
`else
    logic [FOLD_W-1:0]      unused_fold_sum;
    logic [R45_W-1:0]       r45;

    mod45_fold u_fold (
        .q        (q),
        .fold_sum (unused_fold_sum),
        .r45      (r45)
    );

    assign modulo_next = OUT_W'({r45, r8});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modulo_reg <= '0;
        end else begin
            modulo_reg <= modulo_next;
        end
    end

    assign modulo = modulo_reg;

endmodule

// File: tb/tb_modulo_360.sv
// ---------------------------------------------------------------------------
// tb_modulo_360
// Scoreboard bench for modulo_360: the stimulus pushes expected residues,
// a monitor pops and compares them LATENCY edges after each input.
// ---------------------------------------------------------------------------
module tb_modulo_360;
    import modulo_360_pkg::*;

    typedef struct {
        int din;
        int exp;
        bit verbose;
    } sb_item_t;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [15:0] in;
    logic [8:0]  modulo;

    logic        issue;
    logic [3:0]  vld_sh;
    sb_item_t    exp_q[$];

    int n_vec;
    int n_miss;

    modulo_360 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .modulo (modulo)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Drive a vector in the current half-cycle and record its expectation.
    task automatic issue_vec(input int v, input int e, input bit verbose);
        sb_item_t it;
        in    = 16'(v);
        issue = 1'b1;
        it.din = v;
        it.exp = e;
        it.verbose = verbose;
        exp_q.push_back(it);
    endtask

    task automatic apply(input int v, input int e, input bit verbose);
        @(negedge clk);
        issue_vec(v, e, verbose);
    endtask

    task automatic idle_drain(input string name);
        @(negedge clk);
        issue = 1'b0;
        repeat (LATENCY + 2) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: tracks which edges captured a vector, compares LATENCY edges later.
    always @(posedge clk) begin
        if (!rst_n) begin
            vld_sh = '0;
        end else begin
            vld_sh = {vld_sh[2:0], issue};
        end
        #1;
        if (rst_n && vld_sh[LATENCY-1]) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL scoreboard_empty: got output %0d, expected no output", modulo);
            end else begin
                sb_item_t it;
                it = exp_q.pop_front();
                n_vec++;
                if (int'(modulo) != it.exp) begin
                    n_miss++;
                    $display("FAIL vec in=%0d: got %0d, expected %0d", it.din, modulo, it.exp);
                end else if (it.verbose) begin
                    $display("ok   vec in=%0d -> %0d", it.din, modulo);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dir_in  [10] = '{50, 360, 361, 1000, 65535, 0, 359, 719, 720, 65520};
        int dir_exp [10] = '{50, 0,   1,   280,  15,    0, 359, 359, 0,   0};
        int str_exp [11] = '{355, 356, 357, 358, 359, 0, 1, 2, 3, 4, 5};

        n_vec  = 0;
        n_miss = 0;
        vld_sh = '0;
        issue  = 1'b0;
        clk_en = 1'b0;
        rst_n  = 1'b1;
        in     = 16'd1000;

        // Reset with no clock running: output must clear asynchronously.
        #3 rst_n = 1'b0;
        #1 check("rst_async", int'(modulo), 0);

        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release", int'(modulo), 0);
        issue_vec(1000, 280, 1'b1);

        for (int i = 0; i < 10; i++) begin
            apply(dir_in[i], dir_exp[i], 1'b1);
        end

        for (int i = 0; i < 11; i++) begin
            apply(355 + i, str_exp[i], 1'b1);
        end
        idle_drain("drain_directed");

        // Mid-stream asynchronous reset between edges.
        apply(100, 100, 1'b1);
        apply(101, 101, 1'b1);
        apply(102, 102, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1 check("rst_mid", int'(modulo), 0);
        exp_q.delete();
        issue = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_mid_release", int'(modulo), 0);
        apply(725, 5, 1'b1);
        apply(1079, 359, 1'b1);
        idle_drain("drain_after_rst");

        // Full sweep against a plain remainder model.
        for (int v = 0; v < 65536; v++) begin
            apply(v, v % MOD_VAL, 1'b0);
        end
        idle_drain("drain_sweep");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
